// File: rtl/jk_pkg.sv
// jk_pkg: shared types for the JK command sequencer.
// Opcodes, FSM states, the queued command bundle and JK next-state.
package jk_pkg;

    localparam int REP_MAX_W = 8;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_RST  = 2'b01,
        OP_SET  = 2'b10,
        OP_TGL  = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        op_e                  op;
        logic [REP_MAX_W-1:0] rep;
    } cmd_t;

    function automatic logic jk_next(input logic q, input op_e op);
        logic nq;
        nq = q;
        unique case (op)
            OP_HOLD: nq = q;
            OP_RST:  nq = 1'b0;
            OP_SET:  nq = 1'b1;
            OP_TGL:  nq = ~q;
        endcase
        return nq;
    endfunction

    function automatic logic is_abs(input op_e op);
        return (op == OP_RST) || (op == OP_SET);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: power-of-two command queue with wrap-bit pointers.
// Full blocks a push even when a pop happens on the same edge.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB separates full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since empty gates reads
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues {op,rep} commands and drives J/K for rep+1
// cycles each, while checking the downstream flip-flop's q feedback.
module jk_cmd_sequencer
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [REP_W-1:0] cmd_rep,
    output logic             J,
    output logic             K,
    input  logic             q_in,
    input  logic             err_clr,
    output logic             busy,
    output logic             err,
    output logic [7:0]       err_count
);

    cmd_t                 push_cmd;
    cmd_t                 head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 last;
    state_e               state;
    state_e               state_nxt;
    logic [REP_MAX_W-1:0] rem;
    op_e                  cur_op;
    logic                 exp_q;
    logic                 exp_vld;
    logic                 mismatch;

    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign push_cmd  = '{op: op_e'(cmd_op), rep: REP_MAX_W'(cmd_rep)};
    assign last      = (rem == '0);
    assign busy      = (state == ST_ISSUE) || !empty;
    assign cur_op    = op_e'({J, K});
    assign mismatch  = exp_vld && (q_in != exp_q);

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state: leave IDLE on any queued entry, return when drained
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (!empty)         state_nxt = ST_ISSUE;
            ST_ISSUE: if (last && empty)  state_nxt = ST_IDLE;
        endcase
    end

    // Pop the head when idle or on the final cycle of a command
    always_comb begin
        pop = 1'b0;
        unique case (state)
            ST_IDLE:  pop = !empty;
            ST_ISSUE: pop = last && !empty;
        endcase
    end

    // J/K drive and remaining-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            J   <= 1'b0;
            K   <= 1'b0;
            rem <= '0;
        end else if (pop) begin
            {J, K} <= head.op;
            rem    <= head.rep;
        end else if (state == ST_ISSUE) begin
            if (last) begin
                J <= 1'b0;
                K <= 1'b0;
            end else begin
                rem <= rem - REP_MAX_W'(1);
            end
        end
    end

    // Expected q tracks the driven J/K once q becomes known
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q   <= 1'b0;
            exp_vld <= 1'b0;
        end else begin
            if (exp_vld || is_abs(cur_op)) exp_q <= jk_next(exp_q, cur_op);
            if (is_abs(cur_op))            exp_vld <= 1'b1;
        end
    end

    // Sticky error flag and saturating count; clear beats a mismatch
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err       <= 1'b0;
            err_count <= 8'd0;
        end else if (mismatch) begin
            err <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: queue-based reference model feeds a scoreboard
// checked at every falling edge, plus directed boundary scenarios.
`timescale 1ns/1ps
module tb_jk_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int REP_W = 4;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op    = 2'b00;
    logic [REP_W-1:0] cmd_rep   = '0;
    logic             err_clr   = 1'b0;
    logic             q_ovr_en  = 1'b0;
    logic             q_ovr_val = 1'b0;
    logic             q_ff;
    logic             q_in;
    logic             cmd_ready;
    logic             J;
    logic             K;
    logic             busy;
    logic             err;
    logic [7:0]       err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] jk;
        logic       busy;
        logic       ready;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic [1:0] op;
        int         rep;
    } cmd_s;

    exp_t sb[$];
    cmd_s m_fifo[$];
    logic [1:0] m_op    = 2'b00;
    int         m_left  = 0;
    logic       m_known = 1'b0;
    logic       m_kq    = 1'b0;
    logic       m_err   = 1'b0;
    int         m_cnt   = 0;

    logic [1:0] d_jk [6] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00};
    logic       d_q  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    assign q_in = q_ovr_en ? q_ovr_val : q_ff;

    always #5 clk = ~clk;

    jk_cmd_sequencer #(
        .DEPTH (DEPTH),
        .REP_W (REP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rep   (cmd_rep),
        .J         (J),
        .K         (K),
        .q_in      (q_in),
        .err_clr   (err_clr),
        .busy      (busy),
        .err       (err),
        .err_count (err_count)
    );

    function automatic logic jk_apply(input logic q, input logic [1:0] jk);
        case (jk)
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return !q;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Downstream JK flip-flop that produces the q feedback
    always @(posedge clk) begin
        if (rst) q_ff <= 1'b0;
        else     q_ff <= jk_apply(q_ff, {J, K});
    end

    // Reference model: one expected output set per clock edge
    always @(posedge clk) begin
        logic [1:0] drv;
        logic       accept;
        cmd_s       c;
        exp_t       e;
        if (rst) begin
            m_fifo.delete();
            m_left  = 0;
            m_op    = 2'b00;
            m_known = 1'b0;
            m_kq    = 1'b0;
            m_err   = 1'b0;
            m_cnt   = 0;
        end else begin
            drv    = (m_left > 0) ? m_op : 2'b00;
            accept = cmd_valid && (m_fifo.size() < DEPTH);
            if (err_clr) begin
                m_err = 1'b0;
                m_cnt = 0;
            end else if (m_known && (q_in != m_kq)) begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            if (drv == 2'b01 || drv == 2'b10) m_known = 1'b1;
            m_kq = jk_apply(m_kq, drv);
            if (m_left > 1) begin
                m_left--;
            end else if (m_fifo.size() > 0) begin
                c      = m_fifo.pop_front();
                m_op   = c.op;
                m_left = c.rep + 1;
            end else begin
                m_left = 0;
            end
            if (accept) begin
                c.op  = cmd_op;
                c.rep = int'(cmd_rep);
                m_fifo.push_back(c);
            end
        end
        e.jk    = (m_left > 0) ? m_op : 2'b00;
        e.busy  = (m_left > 0) || (m_fifo.size() > 0);
        e.ready = (m_fifo.size() < DEPTH);
        e.err   = m_err;
        e.cnt   = 8'(m_cnt);
        sb.push_back(e);
    end

    // Monitor: compare DUT outputs against the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_jk",    {J, K},    e.jk);
            chk("sb_busy",  busy,      e.busy);
            chk("sb_ready", cmd_ready, e.ready);
            chk("sb_err",   err,       e.err);
            chk("sb_cnt",   err_count, e.cnt);
        end
    end

    task automatic send(input logic [1:0] op, input int rep, output int waited);
        waited    = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rep   = rep[REP_W-1:0];
        while (!cmd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL send_wait ready=%0b required=1", cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        q_ovr_en  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        @(negedge clk);
        chk("rst_jk",    {J, K},    2'b00);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_cnt",   err_count, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back SET/TGL/RST with exact J/K and q trace
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_rep = 4'd0;
        @(negedge clk);
        cmd_op = 2'b11; cmd_rep = 4'd2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                cmd_op = 2'b01; cmd_rep = 4'd0;
            end else if (i == 1) begin
                cmd_valid = 1'b0;
            end
            chk($sformatf("seq_jk%0d", i), {J, K}, d_jk[i]);
            chk($sformatf("seq_q%0d", i),  q_ff,   d_q[i]);
        end
        chk("seq_err", err, 1'b0);

        // Fill the queue behind a long command; fifth push must wait
        do_reset();
        send(2'b10, 15, w);
        for (int i = 0; i < 4; i++) send(2'b01, 0, w);
        chk("full_ready", cmd_ready, 1'b0);
        send(2'b11, 1, w);
        chk("full_wait", w, 13);
        repeat (20) @(negedge clk);

        // Forced mismatch after SET, then clear
        do_reset();
        send(2'b10, 7, w);
        repeat (3) @(negedge clk);
        chk("mm_pre", err, 1'b0);
        q_ovr_en = 1'b1; q_ovr_val = 1'b0;
        @(negedge clk);
        chk("mm_err1", err, 1'b1);
        chk("mm_cnt1", err_count, 8'd1);
        repeat (2) @(negedge clk);
        chk("mm_cnt3", err_count, 8'd3);
        q_ovr_en = 1'b0;
        @(negedge clk);
        chk("mm_hold", err_count, 8'd3);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("mm_clr_err", err, 1'b0);
        chk("mm_clr_cnt", err_count, 8'd0);

        // TGL without a prior RST/SET: q is unknown, no errors
        do_reset();
        q_ovr_en = 1'b1; q_ovr_val = 1'($urandom_range(0, 1));
        send(2'b11, 3, w);
        for (int i = 0; i < 8; i++) begin
            q_ovr_val = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        q_ovr_en = 1'b0;
        chk("unk_err", err, 1'b0);
        chk("unk_cnt", err_count, 8'd0);

        // Reset in the middle of a long TGL with three entries queued
        do_reset();
        send(2'b11, 15, w);
        send(2'b01, 2, w);
        send(2'b10, 3, w);
        send(2'b11, 1, w);
        repeat (2) @(negedge clk);
        do_reset();
        chk("abort_jk",    {J, K},    2'b00);
        chk("abort_busy",  busy,      1'b0);
        chk("abort_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("abort_quiet", {J, K, busy}, 3'b000);
        end

        // Long forced mismatch saturates the counter
        do_reset();
        send(2'b10, 15, w);
        repeat (3) @(negedge clk);
        q_ovr_en = 1'b1; q_ovr_val = 1'b0;
        repeat (300) @(negedge clk);
        chk("sat_cnt", err_count, 8'd255);
        chk("sat_err", err, 1'b1);
        q_ovr_en = 1'b0;

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(0, 99) < 60);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_rep   = ($urandom_range(0, 3) == 0) ?
                        REP_W'($urandom_range(0, 15)) :
                        REP_W'($urandom_range(0, 2));
            err_clr   = ($urandom_range(0, 99) < 3);
            q_ovr_en  = ($urandom_range(0, 99) < 5);
            q_ovr_val = 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        q_ovr_en  = 1'b0;
        rst       = 1'b0;
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
